instr_prefetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 73 +++++++
 rtl/instr_prefetch_unit.sv | 123 ++++++++++++
 tb/tb_instr_prefetch_unit.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// ============================================================================
// Module : fetch_pkg
// Brief  : Shared types and defaults for the instruction prefetch unit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int PC_STEP_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module : sync_fifo
// Brief  : Power-of-two FIFO with flush and count; head entry read directly.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head_data,
  output logic                     not_empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  // Flush suppresses a same-cycle push so the buffer is truly empty afterwards.
  assign do_push = push && !flush && (cnt_q != FULL_COUNT);
  assign do_pop  = pop  && !flush && (cnt_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem[i] <= '0;
      end else if (do_push && (wr_ptr == AW'(i))) begin
        mem[i] <= push_data;
      end
    end
  end

  assign head_data = mem[rd_ptr];
  assign not_empty = (cnt_q != '0);
  assign count     = cnt_q;

endmodule

`default_nettype wire

// File: rtl/instr_prefetch_unit.sv
// ============================================================================
// Module : instr_prefetch_unit
// Brief  : Single-outstanding instruction fetcher with FIFO and redirect flush.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module instr_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int               XLEN     = XLEN_DEF,
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0,
  parameter int               PC_STEP  = PC_STEP_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic [XLEN-1:0]            mem_req_addr,
  input  logic                       mem_rsp_valid,
  input  logic [31:0]                mem_rsp_data,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [31:0]                inst_data,
  output logic [XLEN-1:0]            inst_pc,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int              CW        = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] STEP      = XLEN'(PC_STEP);
  localparam logic [CW-1:0]   DEPTH_CNT = CW'(DEPTH);

  fetch_state_t    state;
  fetch_state_t    state_next;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] fetch_pc_next;
  logic [XLEN-1:0] issued_pc;
  logic            req_fire;
  logic            fifo_push;
  logic            fifo_pop;
  logic [XLEN+31:0] head;

  // Gating on free space here is what guarantees the FIFO can never overflow.
  assign mem_req_valid = (state == REQ) && (occupancy < DEPTH_CNT);
  assign mem_req_addr  = fetch_pc;
  assign req_fire      = mem_req_valid && mem_req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      issued_pc <= '0;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      if (req_fire) issued_pc <= fetch_pc;
    end
  end

  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    fifo_push     = 1'b0;
    if (redirect_valid) begin
      // An outstanding (or just-accepted) request must have its response dropped.
      fetch_pc_next = redirect_pc;
      if (req_fire || (state == WAIT) || (state == DROP)) begin
        state_next = mem_rsp_valid ? REQ : DROP;
      end else begin
        state_next = REQ;
      end
    end else begin
      case (state)
        IDLE: state_next = REQ;
        REQ: begin
          if (req_fire) begin
            state_next    = WAIT;
            fetch_pc_next = fetch_pc + STEP;
          end
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            fifo_push  = 1'b1;
            state_next = REQ;
          end
        end
        DROP: begin
          if (mem_rsp_valid) state_next = REQ;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign fifo_pop = inst_ready && !redirect_valid;

  sync_fifo #(
    .WIDTH (XLEN + 32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data ({issued_pc, mem_rsp_data}),
    .pop       (fifo_pop),
    .flush     (redirect_valid),
    .head_data (head),
    .not_empty (inst_valid),
    .count     (occupancy)
  );

  assign inst_pc   = head[XLEN+31:32];
  assign inst_data = head[31:0];

  a_rsp_protocol: assert property (@(posedge clk) disable iff (!rst_n)
    !(mem_rsp_valid && ((state == IDLE) || (state == REQ))));

endmodule

`default_nettype wire

// File: tb/tb_instr_prefetch_unit.sv
// ============================================================================
// Module : tb_instr_prefetch_unit
// Brief  : Self-checking bench with memory model, scoreboard and redirect table.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_instr_prefetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [2:0]  occupancy;

  logic        b_rst_n;
  logic        b_req_valid;
  logic        b_req_ready;
  logic [31:0] b_req_addr;
  logic        b_rsp_valid;
  logic [31:0] b_rsp_data;
  logic        b_redirect_valid;
  logic [31:0] b_redirect_pc;
  logic        b_inst_valid;
  logic        b_inst_ready;
  logic [31:0] b_inst_data;
  logic [31:0] b_inst_pc;
  logic [2:0]  b_occ;

  always #5 clk = ~clk;

  instr_prefetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0), .PC_STEP(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
    .inst_pc(inst_pc), .occupancy(occupancy)
  );

  instr_prefetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) dut_wrap (
    .clk(clk), .rst_n(b_rst_n),
    .mem_req_valid(b_req_valid), .mem_req_ready(b_req_ready), .mem_req_addr(b_req_addr),
    .mem_rsp_valid(b_rsp_valid), .mem_rsp_data(b_rsp_data),
    .redirect_valid(b_redirect_valid), .redirect_pc(b_redirect_pc),
    .inst_valid(b_inst_valid), .inst_ready(b_inst_ready), .inst_data(b_inst_data),
    .inst_pc(b_inst_pc), .occupancy(b_occ)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [31:0] target;
    int          lat;
    int          k;
    int          gap;
  } redir_vec_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          lat = 1;
  bit          pending = 0;
  int          cnt = 0;
  logic [31:0] paddr = '0;
  bit          stale = 0;
  logic [31:0] exp_addr = '0;
  bit          accepted = 0;
  logic [31:0] last_acc_addr = '0;
  bit          popped = 0;
  logic [31:0] last_pop_pc = '0;
  int          pops = 0;

  function automatic logic [31:0] fn_word(input logic [31:0] a);
    return (a * 32'd3) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: memory model, scoreboard pop/push, request address check.
  task automatic tick();
    logic [31:0] rpc;
    bit          fired;
    bit          rstale;
    exp_t        e;
    fired  = 0;
    rstale = 0;
    rpc    = '0;
    chk("occupancy", 32'(occupancy), 32'(sb.size()));
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    if (pending) begin
      if (cnt <= 1) begin
        fired         = 1;
        rpc           = paddr;
        rstale        = stale;
        pending       = 0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = fn_word(paddr);
      end else begin
        cnt--;
      end
    end
    popped = 0;
    if (inst_valid && inst_ready && !redirect_valid) begin
      popped      = 1;
      last_pop_pc = inst_pc;
      pops++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got pc %h, expected no instruction", inst_pc);
      end else begin
        e = sb.pop_front();
        chk("inst_pc", inst_pc, e.pc);
        chk("inst_data", inst_data, e.data);
      end
    end
    if (fired && !rstale && !redirect_valid) sb.push_back('{rpc, fn_word(rpc)});
    accepted = 0;
    if (mem_req_valid && mem_req_ready) begin
      accepted      = 1;
      last_acc_addr = mem_req_addr;
      chk("req_addr", mem_req_addr, exp_addr);
      pending  = 1;
      cnt      = lat;
      paddr    = exp_addr;
      stale    = 0;
      exp_addr = exp_addr + 32'd4;
    end
    if (redirect_valid) begin
      sb.delete();
      stale    = 1;
      exp_addr = redirect_pc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    mem_rsp_valid  = 1'b0;
    pending        = 0;
    stale          = 0;
    sb.delete();
    exp_addr       = 32'h0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  redir_vec_t vecs[5];

  initial begin
    int n;
    vecs[0] = '{32'h0000_0100, 3, 1, 3};
    vecs[1] = '{32'h0000_0200, 2, 2, 1};
    vecs[2] = '{32'h0000_03F0, 2, 0, 3};
    vecs[3] = '{32'h0000_0040, 1, 1, 1};
    vecs[4] = '{32'hFFFF_FFF8, 4, 2, 3};

    rst_n = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    b_rst_n = 1'b0; b_req_ready = 1'b1; b_rsp_valid = 1'b0; b_rsp_data = '0;
    b_redirect_valid = 1'b0; b_redirect_pc = '0; b_inst_ready = 1'b0;

    // Reset values and first request
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_valid", 32'(mem_req_valid), 32'h0);
    chk("rst_req_addr", mem_req_addr, 32'h0);
    chk("rst_inst_valid", 32'(inst_valid), 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_inst_data", inst_data, 32'h0);
    chk("rst_occupancy", 32'(occupancy), 32'h0);
    rst_n = 1'b1;
    chk("idle_req_valid", 32'(mem_req_valid), 32'h0);
    tick();
    chk("first_req_valid", 32'(mem_req_valid), 32'h1);
    chk("first_req_addr", mem_req_addr, 32'h0);

    // Streaming with 1-cycle memory
    mem_req_ready = 1'b1;
    inst_ready    = 1'b1;
    lat           = 1;
    pops          = 0;
    n = 0;
    while (pops < 4 && n < 40) begin tick(); n++; end
    chk("stream_pops", 32'(pops), 32'h4);

    // Fill with decode stalled, then resume
    reset_dut();
    inst_ready = 1'b0;
    n = 0;
    while (occupancy != 3'd4 && n < 40) begin tick(); n++; end
    chk("full_occupancy", 32'(occupancy), 32'h4);
    repeat (3) tick();
    chk("full_req_valid", 32'(mem_req_valid), 32'h0);
    chk("full_hold_occ", 32'(occupancy), 32'h4);
    inst_ready = 1'b1;
    n = 0;
    accepted = 0;
    while (!accepted && n < 10) begin tick(); n++; end
    chk("resume_seen", 32'(accepted), 32'h1);
    chk("resume_addr", last_acc_addr, 32'h10);
    repeat (8) tick();

    // Redirect table
    for (int v = 0; v < 5; v++) begin
      lat = vecs[v].lat;
      n = 0;
      while (!mem_req_valid && n < 20) begin tick(); n++; end
      for (int j = 0; j <= vecs[v].k; j++) begin
        if (j == vecs[v].k) begin
          redirect_valid = 1'b1;
          redirect_pc    = vecs[v].target;
        end
        tick();
        redirect_valid = 1'b0;
      end
      n = 1;
      while (!mem_req_valid && n < 20) begin tick(); n++; end
      chk("redir_gap", 32'(n), 32'(vecs[v].gap));
      chk("redir_addr", mem_req_addr, vecs[v].target);
      n = 0;
      popped = 0;
      while (!popped && n < 20) begin tick(); n++; end
      chk("redir_first_pc", last_pop_pc, vecs[v].target);
      repeat (10) tick();
    end

    // Flush beats a same-cycle pop
    lat = 1;
    inst_ready = 1'b0;
    n = 0;
    while (occupancy < 3'd2 && n < 20) begin tick(); n++; end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0500;
    inst_ready     = 1'b1;
    tick();
    redirect_valid = 1'b0;
    chk("flush_inst_valid", 32'(inst_valid), 32'h0);
    chk("flush_occupancy", 32'(occupancy), 32'h0);
    n = 0;
    popped = 0;
    while (!popped && n < 20) begin tick(); n++; end
    chk("flush_first_pc", last_pop_pc, 32'h0000_0500);
    repeat (6) tick();

    // Wrapping reset pc and reset during WAIT
    b_rst_n = 1'b1;
    @(posedge clk); #1;
    chk("wrap_req_valid", 32'(b_req_valid), 32'h1);
    chk("wrap_req_addr0", b_req_addr, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    b_rsp_valid = 1'b1;
    b_rsp_data  = 32'hCAFE_0001;
    @(posedge clk); #1;
    b_rsp_valid = 1'b0;
    chk("wrap_inst_valid", 32'(b_inst_valid), 32'h1);
    chk("wrap_inst_pc", b_inst_pc, 32'hFFFF_FFFC);
    chk("wrap_inst_data", b_inst_data, 32'hCAFE_0001);
    chk("wrap_req_addr1", b_req_addr, 32'h0);
    @(posedge clk); #1;
    chk("wait_req_valid", 32'(b_req_valid), 32'h0);
    b_rst_n = 1'b0;
    #1;
    chk("midrst_req_addr", b_req_addr, 32'hFFFF_FFFC);
    chk("midrst_occ", 32'(b_occ), 32'h0);
    chk("midrst_inst_valid", 32'(b_inst_valid), 32'h0);
    @(posedge clk); #1;
    b_rst_n = 1'b1;
    @(posedge clk); #1;
    chk("restart_req_valid", 32'(b_req_valid), 32'h1);
    chk("restart_req_addr", b_req_addr, 32'hFFFF_FFFC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
